// File: rtl/dm_responder.sv
// Data-memory responder: services one read or write per req/ack handshake after a fixed
// number of wait states, flags out-of-range addresses and counts completed transactions.
module dm_responder #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [15:0]       txn_cnt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         txn_cnt_q, txn_cnt_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                do_acc;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                in_range;
    logic [IDX_W-1:0]    idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        do_acc    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access happens on the accepting edge itself.
                        state_d   = StResp;
                        do_acc    = 1'b1;
                        acc_we    = we;
                        acc_addr  = addr;
                        acc_wdata = wdata;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    do_acc  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Full address width is range-checked; only then are the low bits used as an index.
    assign in_range = 32'(acc_addr) < DEPTH;
    assign idx      = acc_addr[IDX_W-1:0];

    always_comb begin
        ack_d     = do_acc;
        err_d     = do_acc & ~in_range;
        rdata_d   = rdata_q;
        txn_cnt_d = txn_cnt_q;
        if (do_acc) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
            if (!in_range) begin
                rdata_d = '0;
            end else if (!acc_we) begin
                rdata_d = mem[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            txn_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    // Storage is not reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_f && do_acc && acc_we && in_range) begin
            mem[idx] <= acc_wdata;
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign txn_cnt = txn_cnt_q;
    assign busy    = state_q != StIdle;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a 2-wait-state instance and a zero-wait instance,
// directed scenarios plus random traffic against a plain behavioural memory model.
module tb_dm_responder;

    logic        clk;
    logic        rst_f;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [15:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        ack_s   [2];
    logic [31:0] rdata_s [2];
    logic        err_s   [2];
    logic        busy_s  [2];
    logic [15:0] txn_s   [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state per instance
    logic [31:0] m_mem   [2][256];
    logic [31:0] m_rdata [2];
    logic [15:0] m_txn   [2];

    dm_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_f(rst_f), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .ack(ack_s[0]), .rdata(rdata_s[0]), .err(err_s[0]),
        .busy(busy_s[0]), .txn_cnt(txn_s[0])
    );

    dm_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_f(rst_f), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .ack(ack_s[1]), .rdata(rdata_s[1]), .err(err_s[1]),
        .busy(busy_s[1]), .txn_cnt(txn_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int waits(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_idle_regs(input int s, input string tag);
        check({tag, "_ack"},  32'(ack_s[s]),  32'd0);
        check({tag, "_err"},  32'(err_s[s]),  32'd0);
        check({tag, "_busy"}, 32'(busy_s[s]), 32'd0);
        check({tag, "_rd"},   rdata_s[s],     32'd0);
        check({tag, "_txn"},  32'(txn_s[s]),  32'd0);
    endtask

    // Apply the memory-side rules to the model and return what the ack cycle must show.
    task automatic model_access(input int s, input logic w, input logic [15:0] a,
                                input logic [31:0] d, output logic exp_err);
        exp_err = (a >= 16'd256);
        if (exp_err) m_rdata[s] = 32'd0;
        else if (w) m_mem[s][a[7:0]] = d;
        else m_rdata[s] = m_mem[s][a[7:0]];
        m_txn[s] = m_txn[s] + 16'd1;
    endtask

    task automatic do_txn(input int s, input logic w, input logic [15:0] a, input logic [31:0] d);
        int   lat;
        logic got;
        logic exp_err;
        @(negedge clk);
        req_s[s] = 1'b1; we_s[s] = w; addr_s[s] = a; wdata_s[s] = d;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (ack_s[s]) got = 1'b1;
            else check("busy_in_wait", 32'(busy_s[s]), 32'd1);
        end
        check("ack_latency", 32'(lat), 32'(waits(s) + 1));
        req_s[s] = 1'b0;
        model_access(s, w, a, d, exp_err);
        check("busy_at_ack", 32'(busy_s[s]), 32'd1);
        check("err_at_ack", 32'(err_s[s]), 32'(exp_err));
        check("rdata_at_ack", rdata_s[s], m_rdata[s]);
        check("txn_at_ack", 32'(txn_s[s]), 32'(m_txn[s]));
        @(negedge clk);
        check("ack_drops", 32'(ack_s[s]), 32'd0);
        check("busy_drops", 32'(busy_s[s]), 32'd0);
        check("rdata_held", rdata_s[s], m_rdata[s]);
    endtask

    initial begin
        int          first_ack;
        int          second_ack;
        int          bound;
        logic        exp_err;
        logic        w;
        logic [15:0] a;
        int          s;

        for (int k = 0; k < 2; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
            m_rdata[k] = '0; m_txn[k] = '0;
            for (int j = 0; j < 256; j++) m_mem[k][j] = '0;
        end
        rst_f = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_regs(0, "reset0");
        check_idle_regs(1, "reset1");
        rst_f = 1'b1;

        // Give every word a known value so the model does not depend on power-up contents.
        for (int j = 0; j < 256; j++) begin
            do_txn(0, 1'b1, 16'(j), 32'd0);
            do_txn(1, 1'b1, 16'(j), 32'd0);
        end
        @(negedge clk);
        rst_f = 1'b0;
        m_txn[0] = '0; m_txn[1] = '0; m_rdata[0] = '0; m_rdata[1] = '0;
        @(negedge clk);
        check_idle_regs(0, "rereset0");
        rst_f = 1'b1;

        // Basic write then read-back
        do_txn(0, 1'b1, 16'h0005, 32'hDEADBEEF);
        do_txn(0, 1'b0, 16'h0005, 32'h0);
        check("read_back_5", rdata_s[0], 32'hDEADBEEF);

        // Out-of-range accesses never alias onto low words
        do_txn(0, 1'b1, 16'h0100, 32'h12345678);
        do_txn(0, 1'b0, 16'h0000, 32'h0);
        do_txn(0, 1'b0, 16'h0100, 32'h0);
        do_txn(0, 1'b1, 16'h8005, 32'h11111111);
        do_txn(0, 1'b0, 16'h0005, 32'h0);

        // Back-to-back: req stays high through the ack cycle
        @(negedge clk);
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 16'h0005;
        first_ack = -1; second_ack = -1; bound = 0;
        while (second_ack < 0 && bound < 30) begin
            @(negedge clk);
            bound++;
            if (ack_s[0]) begin
                if (first_ack < 0) begin
                    first_ack = cyc;
                    model_access(0, 1'b0, 16'h0005, 32'h0, exp_err);
                    check("b2b_rd1", rdata_s[0], m_rdata[0]);
                end else begin
                    second_ack = cyc;
                    req_s[0] = 1'b0;
                    model_access(0, 1'b0, 16'h0005, 32'h0, exp_err);
                    check("b2b_rd2", rdata_s[0], m_rdata[0]);
                end
            end
        end
        req_s[0] = 1'b0;
        check("b2b_spacing", 32'(second_ack - first_ack), 32'd4);
        check("b2b_txn", 32'(txn_s[0]), 32'(m_txn[0]));

        // Reset during WAIT discards the pending write
        do_txn(0, 1'b1, 16'h0007, 32'h0);
        @(negedge clk);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 16'h0007; wdata_s[0] = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy_s[0]), 32'd1);
        rst_f = 1'b0;
        req_s[0] = 1'b0;
        #1;
        check("rst_busy", 32'(busy_s[0]), 32'd0);
        check("rst_ack", 32'(ack_s[0]), 32'd0);
        check("rst_txn", 32'(txn_s[0]), 32'd0);
        m_txn[0] = '0; m_rdata[0] = '0; m_txn[1] = '0; m_rdata[1] = '0;
        @(negedge clk);
        rst_f = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("no_ack_after_rst", 32'(ack_s[0]), 32'd0);
        end
        do_txn(0, 1'b0, 16'h0007, 32'h0);
        check("aborted_write", rdata_s[0], 32'd0);

        // Zero wait states
        do_txn(1, 1'b1, 16'h00FF, 32'hCAFEF00D);
        do_txn(1, 1'b0, 16'h00FF, 32'h0);
        check("zw_read", rdata_s[1], 32'hCAFEF00D);

        // Random traffic on both instances
        for (int i = 0; i < 80; i++) begin
            s = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(256, 65535));
            else a = 16'($urandom_range(0, 255));
            do_txn(s, w, a, $urandom);
        end

        // Counter wrap on the zero-wait instance
        @(negedge clk);
        force u_dut0.txn_cnt_q = 16'hFFFF;
        @(negedge clk);
        release u_dut0.txn_cnt_q;
        m_txn[1] = 16'hFFFF;
        @(negedge clk);
        check("pre_wrap", 32'(txn_s[1]), 32'h0000FFFF);
        do_txn(1, 1'b0, 16'h00FF, 32'h0);
        check("wrap", 32'(txn_s[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
